// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit:
// funct3 encodings, FSM states and operand-signedness helpers.
package mdu_pkg;

    localparam int MDU_XLEN = 64;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [MDU_XLEN-1:0] MIN_INT = {1'b1, {(MDU_XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage request / writeback bundle between the issue logic and the MDU.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int XLEN       = MDU_XLEN,
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic [2:0]            op;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  kill;
    logic                  busy;
    logic                  done;
    logic [XLEN-1:0]       result;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  wr_en;

    modport master (
        output start, op, rs1_val, rs2_val, rd_addr, kill,
        input  busy, done, result, wr_addr, wr_en
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_addr, kill,
        output busy, done, result, wr_addr, wr_en
    );
endinterface

// File: rtl/mdu_neg.sv
// Conditional two's-complement negation; used for operand magnitudes and
// for the final sign correction of product, quotient and remainder.
module mdu_neg #(
    parameter int W = 64
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    assign dout = neg ? (~din + W'(1)) : din;
endmodule

// File: rtl/mdu_iterative.sv
// Radix-2 iterative RV64M unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a two-cycle sign-fix stage.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN       = MDU_XLEN,
    parameter int REG_ADDR_W = 5
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  fix_p1;
    logic [2:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       res_q, res_sel;
    logic [XLEN-1:0]       a_mag, b_mag, quo, rem;
    logic [2*XLEN-1:0]     prod;
    logic                  neg_prod, neg_quo, neg_rem;

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic                   a_neg, b_neg, accept, div0, ovf, special;
    logic [XLEN-1:0]        rs1_abs, rs2_abs, quo_fix, rem_fix, addend;
    logic [2*XLEN-1:0]      prod_fix;
    logic [XLEN:0]          mul_sum, div_sh, div_diff;

    assign rs1_s   = $signed(bus.rs1_val);
    assign rs2_s   = $signed(bus.rs2_val);
    assign a_neg   = op_a_signed(bus.op) && (rs1_s < 0);
    assign b_neg   = op_b_signed(bus.op) && (rs2_s < 0);
    assign accept  = (state == IDLE) && bus.start && !bus.kill;
    assign div0    = op_is_div(bus.op) && (bus.rs2_val == '0);
    assign ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.rs1_val == MIN_INT) && (bus.rs2_val == '1);
    assign special = div0 || ovf;

    mdu_neg #(.W(XLEN))   u_abs_a    (.neg(a_neg),    .din(bus.rs1_val), .dout(rs1_abs));
    mdu_neg #(.W(XLEN))   u_abs_b    (.neg(b_neg),    .din(bus.rs2_val), .dout(rs2_abs));
    mdu_neg #(.W(2*XLEN)) u_fix_prod (.neg(neg_prod), .din(prod),        .dout(prod_fix));
    mdu_neg #(.W(XLEN))   u_fix_quo  (.neg(neg_quo),  .din(quo),         .dout(quo_fix));
    mdu_neg #(.W(XLEN))   u_fix_rem  (.neg(neg_rem),  .din(rem),         .dout(rem_fix));

    // Iteration datapath: product high half accumulates, remainder trial-subtracts
    assign addend   = prod[0] ? a_mag : '0;
    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, addend};
    assign div_sh   = {rem, quo[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_mag};

    always_comb begin
        case (op_q)
            OP_MUL:                        res_sel = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  res_sel = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               res_sel = quo;
            OP_REM, OP_REMU:               res_sel = rem;
            default:                       res_sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = special ? FIX : CALC;
            CALC: begin
                if (bus.kill)                  state_nxt = IDLE;
                else if (cnt == CNT_W'(1))     state_nxt = FIX;
            end
            FIX: begin
                if (bus.kill)    state_nxt = IDLE;
                else if (fix_p1) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            fix_p1 <= 1'b0;
            rd_q   <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rd_q   <= bus.rd_addr;
                    cnt    <= special ? '0 : CNT_W'(XLEN);
                    fix_p1 <= 1'b0;
                end
                CALC: cnt <= cnt - CNT_W'(1);
                // FIX is split: negation is registered first so the 128-bit
                // carry chain never feeds the result mux in the same cycle.
                FIX: begin
                    fix_p1 <= ~fix_p1;
                    if (fix_p1 && !bus.kill) res_q <= res_sel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (accept) begin
                op_q     <= bus.op;
                a_mag    <= rs1_abs;
                b_mag    <= rs2_abs;
                prod     <= {{XLEN{1'b0}}, rs2_abs};
                quo      <= rs1_abs;
                rem      <= '0;
                neg_prod <= a_neg ^ b_neg;
                neg_quo  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                if (div0) begin
                    quo     <= '1;
                    rem     <= bus.rs1_val;
                    neg_quo <= 1'b0;
                    neg_rem <= 1'b0;
                end else if (ovf) begin
                    quo     <= MIN_INT;
                    rem     <= '0;
                    neg_quo <= 1'b0;
                    neg_rem <= 1'b0;
                end
            end
            CALC: begin
                if (op_is_div(op_q)) begin
                    quo <= {quo[XLEN-2:0], ~div_diff[XLEN]};
                    rem <= div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                end else begin
                    prod <= {mul_sum, prod[XLEN-1:1]};
                end
            end
            FIX: if (!fix_p1) begin
                prod <= prod_fix;
                quo  <= quo_fix;
                rem  <= rem_fix;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (state == CALC) || (state == FIX);
    assign bus.done    = (state == DONE) && !bus.kill;
    assign bus.wr_en   = bus.done && (rd_q != '0);
    assign bus.result  = res_q;
    assign bus.wr_addr = rd_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed and randomized bench for mdu_iterative against a plain-arithmetic
// RV64M reference model.
module tb_mdu_iterative;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] last_exp;

    mdu_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();
    mdu_iterative #(.XLEN(64), .REG_ADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        return o[2] && ((b == 64'd0) || (((o == OP_DIV) || (o == OP_REM)) && a == MIN_INT && b == '1));
    endfunction

    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa128, ua128, sb128, ub128, p;
        logic signed [63:0] sa, sb, sq;
        sa = a; sb = b;
        sa128 = {{64{a[63]}}, a}; ua128 = {64'd0, a};
        sb128 = {{64{b[63]}}, b}; ub128 = {64'd0, b};
        case (o)
            OP_MUL:    begin p = ua128 * ub128; return p[63:0]; end
            OP_MULH:   begin p = sa128 * sb128; return p[127:64]; end
            OP_MULHSU: begin p = sa128 * ub128; return p[127:64]; end
            OP_MULHU:  begin p = ua128 * ub128; return p[127:64]; end
            OP_DIV: begin
                if (b == 0) return '1;
                if (a == MIN_INT && b == '1) return a;
                sq = sa / sb; return sq;
            end
            OP_DIVU:   return (b == 0) ? '1 : a / b;
            OP_REM: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == '1) return 64'd0;
                sq = sa % sb; return sq;
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Caller must be positioned at a falling edge.
    task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input bit hold);
        logic [63:0] exp_res;
        int exp_lat, k;
        bit seen, busy_ok;
        exp_res = ref_result(o, a, b);
        exp_lat = is_special(o, a, b) ? 2 : 66;
        bus.start = 1'b1; bus.op = o; bus.rs1_val = a; bus.rs2_val = b; bus.rd_addr = rd;
        @(negedge clk);
        bus.start   = hold;
        bus.op      = 3'($urandom);
        bus.rs1_val = {$urandom, $urandom};
        bus.rs2_val = {$urandom, $urandom};
        bus.rd_addr = 5'($urandom);
        k = 0; seen = 0; busy_ok = 1;
        while (!seen && k < 200) begin
            if (bus.done) seen = 1;
            else begin
                if (!bus.busy) busy_ok = 0;
                @(negedge clk);
                k++;
            end
        end
        bus.start = 1'b0;
        check($sformatf("done_seen op%0d", o), seen, 1);
        check($sformatf("latency op%0d", o), k, exp_lat);
        check($sformatf("result op%0d a=%0h b=%0h", o, a, b), bus.result, exp_res);
        check($sformatf("wr_addr op%0d", o), bus.wr_addr, rd);
        check($sformatf("wr_en op%0d rd=%0d", o, rd), bus.wr_en, rd != 0);
        check($sformatf("busy_in_done op%0d", o), bus.busy, 0);
        check($sformatf("busy_until_done op%0d", o), busy_ok, 1);
        last_exp = exp_res;
        @(negedge clk);
        check($sformatf("done_pulse op%0d", o), bus.done, 0);
        check($sformatf("idle_after op%0d", o), bus.busy, 0);
    endtask

    initial begin
        bit saw;
        int k;
        logic [2:0]  ro;
        logic [63:0] ra, rb;
        reset = 1'b1;
        bus.start = 0; bus.op = 0; bus.rs1_val = 0; bus.rs2_val = 0; bus.rd_addr = 0; bus.kill = 0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_wr_en", bus.wr_en, 0);
        check("reset_result", bus.result, 0);
        check("reset_wr_addr", bus.wr_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        do_op(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 0);
        check("mul_7x-3_const", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op(OP_MULHU, '1, '1, 5'd1, 0);
        check("mulhu_ones_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(OP_MULH, '1, '1, 5'd2, 0);
        check("mulh_ones_const", bus.result, 64'd0);
        do_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd3, 0);
        check("div_-20_6_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(OP_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd4, 0);
        check("rem_-20_6_const", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(OP_DIVU, 64'd20, 64'd6, 5'd6, 0);
        do_op(OP_DIVU, 64'd13, 64'd0, 5'd7, 0);
        do_op(OP_REMU, 64'd13, 64'd0, 5'd8, 0);
        check("remu_div0_const", bus.result, 64'd13);
        do_op(OP_DIV, MIN_INT, '1, 5'd9, 0);
        do_op(OP_REM, MIN_INT, '1, 5'd10, 0);
        do_op(OP_MUL, 64'd11, 64'd13, 5'd0, 0);
        do_op(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 1);
        @(negedge clk);
        check("hold_single_op", bus.busy, 0);

        // Flush mid-multiply, then immediately issue a fresh op
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_val = {$urandom, $urandom};
        bus.rs2_val = {$urandom, $urandom}; bus.rd_addr = 5'd7;
        @(negedge clk);
        bus.start = 1'b0;
        saw = 0;
        repeat (9) begin
            if (bus.done) saw = 1;
            @(negedge clk);
        end
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_busy", bus.busy, 0);
        check("kill_no_done", bus.done | saw, 0);
        check("kill_wr_en", bus.wr_en, 0);
        check("kill_result_held", bus.result, last_exp);
        do_op(OP_MUL, 64'd123456789, 64'd987654321, 5'd12, 0);

        // Flush in the DONE cycle masks the strobe combinationally
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs1_val = 64'd13; bus.rs2_val = 64'd0; bus.rd_addr = 5'd9;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0; saw = 0;
        while (!saw && k < 10) begin
            if (bus.done) saw = 1;
            else begin @(negedge clk); k++; end
        end
        check("kdone_seen", saw, 1);
        bus.kill = 1'b1;
        #1;
        check("kdone_done_masked", bus.done, 0);
        check("kdone_wr_en_masked", bus.wr_en, 0);
        @(negedge clk);
        bus.kill = 1'b0;
        check("kdone_idle", bus.busy, 0);
        check("kdone_no_done", bus.done, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = 64'd0;
                1: begin ra = MIN_INT; rb = '1; end
                2: begin
                    ra = 64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 40));
                    if ($urandom_range(0, 1) == 1) ra = ~ra + 64'd1;
                    if ($urandom_range(0, 1) == 1) rb = ~rb + 64'd1;
                end
                default: ;
            endcase
            do_op(ro, ra, rb, 5'($urandom), 0);
        end

        // Asynchronous reset in the middle of a multiply
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1_val = 64'd5; bus.rs2_val = 64'd9; bus.rd_addr = 5'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_wr_en", bus.wr_en, 0);
        check("arst_result", bus.result, 0);
        check("arst_wr_addr", bus.wr_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        saw = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.wr_en) saw = 1;
        end
        check("arst_no_write", saw, 0);
        do_op(OP_DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 5'd31, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
